// File: rtl/mem_stage_if.sv
// Data-memory request/ready bus between the MEM stage (master) and data memory (slave).
// req/we/addr/be/wdata are held stable by the master while req & !ready.
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, be, input ready, rdata);
    modport slave  (input req, we, addr, wdata, be, output ready, rdata);
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores from EX/MEM onto the dmem bus, stalls the
// front of the pipeline while an access is outstanding, and registers MEM/WB.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned half/word accesses are
// suppressed and reported through mem_misaligned_o / mem_badaddr_o).
`ifndef CONTROL_SIGNALS_WIDTH
`define CONTROL_SIGNALS_WIDTH 8
`endif
`ifndef CTRL_MEM_READ
`define CTRL_MEM_READ 0
`endif
`ifndef CTRL_MEM_WRITE
`define CTRL_MEM_WRITE 1
`endif

module mem_stage (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [31:0]                       ex_mem_pc_i,
    input  logic [31:0]                       ex_mem_alu_result_i,
    input  logic [31:0]                       ex_mem_rs2_data_i,
    input  logic [4:0]                        ex_mem_rd_addr_i,
    input  logic [2:0]                        ex_mem_funct3_i,
    input  logic [`CONTROL_SIGNALS_WIDTH-1:0] ex_mem_control_signals_i,
    input  logic                              ex_mem_valid_i,
    mem_stage_if.master                       dmem,
    output logic                              mem_stall_o,
    output logic [31:0]                       mem_wb_pc_o,
    output logic [31:0]                       mem_wb_alu_result_o,
    output logic [31:0]                       mem_wb_mem_data_o,
    output logic [4:0]                        mem_wb_rd_addr_o,
    output logic [`CONTROL_SIGNALS_WIDTH-1:0] mem_wb_control_signals_o,
    output logic                              mem_wb_valid_o,
    output logic                              mem_misaligned_o,
    output logic [31:0]                       mem_badaddr_o
);
    localparam int CW = `CONTROL_SIGNALS_WIDTH;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t state_q, state_d;

    logic        is_read, is_write, memop;
    logic        size_byte, size_half;
    logic        misaligned_c, issue, done;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] load_data;

    // Registered bus outputs plus the access shape needed to extract load data.
    logic        req_q, we_q, load_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    logic [31:0]   wb_pc_q, wb_alu_q, wb_data_q;
    logic [4:0]    wb_rd_q;
    logic [CW-1:0] wb_ctrl_q;
    logic          wb_valid_q;

    assign is_read  = ex_mem_control_signals_i[`CTRL_MEM_READ];
    assign is_write = ex_mem_control_signals_i[`CTRL_MEM_WRITE];
    // READ and WRITE both set resolves to a store, since is_write wins everywhere.
    assign memop    = ex_mem_valid_i & (is_read | is_write);

    // funct3[1:0]: 00 byte, 01 half, anything else is a full word.
    assign size_byte = (ex_mem_funct3_i[1:0] == 2'b00);
    assign size_half = (ex_mem_funct3_i[1:0] == 2'b01);

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned_c = memop &
                          ((size_half & ex_mem_alu_result_i[0]) |
                           (~size_byte & ~size_half & (ex_mem_alu_result_i[1:0] != 2'b00)));
`else
    assign misaligned_c = 1'b0;
`endif

    assign issue       = (state_q == IDLE) & memop & ~misaligned_c;
    assign done        = (state_q == BUSY) & dmem.ready;
    assign mem_stall_o = issue | ((state_q == BUSY) & ~dmem.ready);

    // Store byte lanes and lane-replicated write data; loads enable the whole word.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = 32'h0;
        if (is_write) begin
            wdata_d = ex_mem_rs2_data_i;
            if (size_byte) begin
                be_d    = 4'b0001 << ex_mem_alu_result_i[1:0];
                wdata_d = {4{ex_mem_rs2_data_i[7:0]}};
            end else if (size_half) begin
                be_d    = 4'b0011 << {ex_mem_alu_result_i[1], 1'b0};
                wdata_d = {2{ex_mem_rs2_data_i[15:0]}};
            end
        end
    end

    // Pick the addressed byte/half out of the read word and extend per funct3.
    always_comb begin
        logic [7:0]  bsel;
        logic [15:0] hsel;
        bsel = dmem.rdata[7:0];
        case (off_q)
            2'd1:    bsel = dmem.rdata[15:8];
            2'd2:    bsel = dmem.rdata[23:16];
            2'd3:    bsel = dmem.rdata[31:24];
            default: bsel = dmem.rdata[7:0];
        endcase
        hsel = off_q[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
        load_data = dmem.rdata;
        case (f3_q)
            3'b000:  load_data = {{24{bsel[7]}}, bsel};
            3'b001:  load_data = {{16{hsel[15]}}, hsel};
            3'b100:  load_data = {24'h0, bsel};
            3'b101:  load_data = {16'h0, hsel};
            default: load_data = dmem.rdata;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: IDLE -> BUSY on an issued access, BUSY -> IDLE on ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue)      state_d = BUSY;
            BUSY:    if (dmem.ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus request registers: loaded on issue, held while waiting, req dropped on ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            load_q  <= 1'b0;
            f3_q    <= 3'h0;
            off_q   <= 2'h0;
        end else if (issue) begin
            req_q   <= 1'b1;
            we_q    <= is_write;
            addr_q  <= {ex_mem_alu_result_i[31:2], 2'b00};
            be_q    <= be_d;
            wdata_q <= wdata_d;
            load_q  <= ~is_write;
            f3_q    <= ex_mem_funct3_i;
            off_q   <= ex_mem_alu_result_i[1:0];
        end else if (done) begin
            req_q   <= 1'b0;
        end
    end

    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.addr  = addr_q;
    assign dmem.be    = be_q;
    assign dmem.wdata = wdata_q;

    // MEM/WB register: bubble while stalled, otherwise take the instruction in MEM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_pc_q    <= 32'h0;
            wb_alu_q   <= 32'h0;
            wb_data_q  <= 32'h0;
            wb_rd_q    <= 5'h0;
            wb_ctrl_q  <= '0;
            wb_valid_q <= 1'b0;
        end else if (mem_stall_o) begin
            wb_valid_q <= 1'b0;
        end else begin
            wb_pc_q    <= ex_mem_pc_i;
            wb_alu_q   <= ex_mem_alu_result_i;
            wb_rd_q    <= ex_mem_rd_addr_i;
            wb_ctrl_q  <= ex_mem_control_signals_i;
            wb_valid_q <= ex_mem_valid_i & ~misaligned_c;
            wb_data_q  <= (done & load_q) ? load_data : 32'h0;
        end
    end

    assign mem_wb_pc_o              = wb_pc_q;
    assign mem_wb_alu_result_o      = wb_alu_q;
    assign mem_wb_mem_data_o        = wb_data_q;
    assign mem_wb_rd_addr_o         = wb_rd_q;
    assign mem_wb_control_signals_o = wb_ctrl_q;
    assign mem_wb_valid_o           = wb_valid_q;

`ifdef MEM_MISALIGN_TRAP_EN
    logic        mis_q;
    logic [31:0] badaddr_q;

    // One-cycle misalignment pulse; the faulting address is kept until the next fault.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mis_q     <= 1'b0;
            badaddr_q <= 32'h0;
        end else begin
            mis_q <= misaligned_c & (state_q == IDLE);
            if (misaligned_c) badaddr_q <= ex_mem_alu_result_i;
        end
    end

    assign mem_misaligned_o = mis_q;
    assign mem_badaddr_o    = badaddr_q;
`else
    assign mem_misaligned_o = 1'b0;
    assign mem_badaddr_o    = 32'h0;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed spec vectors, reset mid-access and a
// randomized op stream, all checked against an arithmetic model of loads/stores.
`ifndef CONTROL_SIGNALS_WIDTH
`define CONTROL_SIGNALS_WIDTH 8
`endif
`ifndef CTRL_MEM_READ
`define CTRL_MEM_READ 0
`endif
`ifndef CTRL_MEM_WRITE
`define CTRL_MEM_WRITE 1
`endif

module tb_mem_stage;
    localparam int CW = `CONTROL_SIGNALS_WIDTH;
    localparam int RB = `CTRL_MEM_READ;
    localparam int WB = `CTRL_MEM_WRITE;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [31:0]   pc, alu, rs2;
    logic [4:0]    rd;
    logic [2:0]    f3;
    logic [CW-1:0] ctrl;
    logic          valid;

    logic          stall, wb_valid, mis;
    logic [31:0]   wb_pc, wb_alu, wb_data, badaddr;
    logic [4:0]    wb_rd;
    logic [CW-1:0] wb_ctrl;

    logic [3:0]    obs_be;
    logic [31:0]   obs_wdata;

    int passed = 0;
    int total  = 0;

    mem_stage_if dmem();

    mem_stage dut (
        .clk(clk), .reset(reset),
        .ex_mem_pc_i(pc), .ex_mem_alu_result_i(alu), .ex_mem_rs2_data_i(rs2),
        .ex_mem_rd_addr_i(rd), .ex_mem_funct3_i(f3), .ex_mem_control_signals_i(ctrl),
        .ex_mem_valid_i(valid), .dmem(dmem), .mem_stall_o(stall),
        .mem_wb_pc_o(wb_pc), .mem_wb_alu_result_o(wb_alu), .mem_wb_mem_data_o(wb_data),
        .mem_wb_rd_addr_o(wb_rd), .mem_wb_control_signals_o(wb_ctrl),
        .mem_wb_valid_o(wb_valid), .mem_misaligned_o(mis), .mem_badaddr_o(badaddr)
    );

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f);
        if (f[1:0] == 2'b00) return 1;
        if (f[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f, input logic [31:0] a, input bit st);
        int off = int'(a % 4);
        if (!st) return 4'hF;
        if (size_of(f) == 1) return 4'((1 << off));
        if (size_of(f) == 2) return 4'((3 << (off / 2 * 2)));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] d);
        if (size_of(f) == 1) return (d & 32'hFF) * 32'h01010101;
        if (size_of(f) == 2) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] w);
        int off = int'(a % 4);
        logic [31:0] v;
        if (size_of(f) == 1) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (f == 3'b000 && v >= 32'h80) v = v | 32'hFFFFFF00;
            return v;
        end
        if (size_of(f) == 2) begin
            v = (w >> (8 * (off / 2 * 2))) & 32'hFFFF;
            if (f == 3'b001 && v >= 32'h8000) v = v | 32'hFFFF0000;
            return v;
        end
        return w;
    endfunction

    function automatic bit m_misal(input logic [2:0] f, input logic [31:0] a);
        return (size_of(f) == 2 && a % 2 != 0) || (size_of(f) == 4 && a % 4 != 0);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] p, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] r, input logic [2:0] f, input logic [CW-1:0] c,
                         input logic v);
        pc = p; alu = a; rs2 = d; rd = r; f3 = f; ctrl = c; valid = v;
    endtask

    // One memory access end to end, with ws wait states before ready.
    task automatic run_memop(input logic [31:0] p, input logic [31:0] a, input logic [31:0] d,
                             input logic [4:0] r, input logic [2:0] f, input logic [CW-1:0] c,
                             input int ws, input logic [31:0] rdata);
        bit st = c[WB];
        drive(p, a, d, r, f, c, 1'b1);
        dmem.ready = 1'b0;
        @(negedge clk);
        total++; if (stall !== 1'b1) $display("FAIL issue_stall got %b want 1", stall); else passed++;
        total++; if (dmem.req !== 1'b0) $display("FAIL issue_req got %b want 0", dmem.req); else passed++;
        step();
        for (int w = 0; w <= ws; w++) begin
            dmem.ready = (w == ws);
            dmem.rdata = (w == ws) ? rdata : $urandom();
            @(negedge clk);
            total++; if (dmem.req !== 1'b1) $display("FAIL busy_req got %b want 1", dmem.req); else passed++;
            total++; if (dmem.we !== st) $display("FAIL busy_we got %b want %b", dmem.we, st); else passed++;
            total++; if (dmem.addr !== (a & ~32'h3)) $display("FAIL busy_addr got %h want %h", dmem.addr, a & ~32'h3); else passed++;
            total++; if (dmem.be !== m_be(f, a, st)) $display("FAIL busy_be got %b want %b", dmem.be, m_be(f, a, st)); else passed++;
            if (st) begin
                total++; if (dmem.wdata !== m_wdata(f, d)) $display("FAIL busy_wdata got %h want %h", dmem.wdata, m_wdata(f, d)); else passed++;
            end
            total++; if (stall !== (w != ws)) $display("FAIL busy_stall got %b want %b", stall, w != ws); else passed++;
            total++; if (wb_valid !== 1'b0) $display("FAIL busy_wbvalid got %b want 0", wb_valid); else passed++;
            obs_be = dmem.be;
            obs_wdata = dmem.wdata;
            step();
        end
        dmem.ready = 1'b0;
        valid = 1'b0;
        total++; if (wb_valid !== 1'b1) $display("FAIL done_wbvalid got %b want 1", wb_valid); else passed++;
        total++; if (wb_pc !== p) $display("FAIL done_pc got %h want %h", wb_pc, p); else passed++;
        total++; if (wb_alu !== a) $display("FAIL done_alu got %h want %h", wb_alu, a); else passed++;
        total++; if (wb_rd !== r) $display("FAIL done_rd got %0d want %0d", wb_rd, r); else passed++;
        total++; if (wb_ctrl !== c) $display("FAIL done_ctrl got %h want %h", wb_ctrl, c); else passed++;
        total++; if (dmem.req !== 1'b0) $display("FAIL done_req got %b want 0", dmem.req); else passed++;
        if (!st) begin
            total++; if (wb_data !== m_load(f, a, rdata)) $display("FAIL done_load f3=%0d a=%h got %h want %h", f, a, wb_data, m_load(f, a, rdata)); else passed++;
        end
    endtask

    // Non-memory (or invalid) instruction: one-cycle pass-through, no bus activity.
    task automatic run_alu(input logic [31:0] p, input logic [31:0] a, input logic [4:0] r,
                           input logic [CW-1:0] c, input logic v);
        drive(p, a, $urandom(), r, 3'($urandom_range(0, 7)), c, v);
        @(negedge clk);
        total++; if (stall !== 1'b0) $display("FAIL alu_stall got %b want 0", stall); else passed++;
        total++; if (dmem.req !== 1'b0) $display("FAIL alu_req got %b want 0", dmem.req); else passed++;
        step();
        valid = 1'b0;
        total++; if (wb_alu !== a) $display("FAIL alu_result got %h want %h", wb_alu, a); else passed++;
        total++; if (wb_pc !== p) $display("FAIL alu_pc got %h want %h", wb_pc, p); else passed++;
        total++; if (wb_data !== 32'h0) $display("FAIL alu_memdata got %h want 0", wb_data); else passed++;
        total++; if (wb_valid !== v) $display("FAIL alu_wbvalid got %b want %b", wb_valid, v); else passed++;
`ifndef MEM_MISALIGN_TRAP_EN
        total++; if (mis !== 1'b0 || badaddr !== 32'h0) $display("FAIL alu_mis got %b/%h want 0/0", mis, badaddr); else passed++;
`endif
    endtask

    // ---------------- scenarios ----------------
    logic [CW-1:0] C_LD, C_ST, C_MASK;

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, '0, 1'b0);
        dmem.ready = 1'b0; dmem.rdata = 32'h0;
        reset = 1'b1;
        step(); step();
        total++; if (dmem.req !== 1'b0) $display("FAIL rst_req got %b want 0", dmem.req); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL rst_stall got %b want 0", stall); else passed++;
        total++; if (wb_valid !== 1'b0 || wb_alu !== 32'h0 || wb_pc !== 32'h0) $display("FAIL rst_wb got %b/%h/%h want 0", wb_valid, wb_alu, wb_pc); else passed++;
        total++; if (mis !== 1'b0 || badaddr !== 32'h0) $display("FAIL rst_mis got %b/%h want 0/0", mis, badaddr); else passed++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_spec_vectors();
        run_memop(32'h1000, 32'h100, 32'hDEADBEEF, 5'd3, 3'b010, C_ST, 2, $urandom());
        total++; if (obs_be !== 4'b1111 || obs_wdata !== 32'hDEADBEEF) $display("FAIL sw_lanes got %b/%h want 1111/deadbeef", obs_be, obs_wdata); else passed++;
        run_memop(32'h1004, 32'h203, 32'h0, 5'd4, 3'b000, C_LD, 0, 32'h80FFFF7F);
        total++; if (wb_data !== 32'hFFFFFF80) $display("FAIL lb_const got %h want ffffff80", wb_data); else passed++;
        run_memop(32'h1008, 32'h203, 32'h0, 5'd5, 3'b100, C_LD, 1, 32'h80FFFF7F);
        total++; if (wb_data !== 32'h00000080) $display("FAIL lbu_const got %h want 00000080", wb_data); else passed++;
        run_memop(32'h100C, 32'h2, 32'h0000ABCD, 5'd0, 3'b001, C_ST, 0, 32'h0);
        total++; if (obs_be !== 4'b1100 || obs_wdata !== 32'hABCDABCD) $display("FAIL sh_const got %b/%h want 1100/abcdabcd", obs_be, obs_wdata); else passed++;
        run_memop(32'h1010, 32'h1, 32'h0000005A, 5'd0, 3'b000, C_ST, 0, 32'h0);
        total++; if (obs_be !== 4'b0010) $display("FAIL sb_const got %b want 0010", obs_be); else passed++;
        run_alu(32'h1014, 32'h1234, 5'd7, CW'(8'hA0) & ~C_MASK, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_alu(32'h2000, 32'h55AA, 5'd1, '0, 1'b1);
        run_memop(32'h2004, 32'h306, 32'h0, 5'd2, 3'b101, C_LD, 0, 32'h9876_5432);
        run_memop(32'h2008, 32'h30C, 32'h1357_9BDF, 5'd0, 3'b011, C_ST | C_LD, 0, 32'h0);
        run_alu(32'h200C, 32'h0, 5'd0, '0, 1'b0);
    endtask

    task automatic test_reset_mid_access();
        run_alu(32'h3000, 32'h77, 5'd9, '0, 1'b1);
        drive(32'h3004, 32'h40, 32'h0, 5'd10, 3'b010, C_LD, 1'b1);
        dmem.ready = 1'b0;
        step();
        @(negedge clk);
        total++; if (dmem.req !== 1'b1) $display("FAIL rstmid_pre got %b want 1", dmem.req); else passed++;
        #2 reset = 1'b1;
        #1;
        total++; if (dmem.req !== 1'b0) $display("FAIL rstmid_req got %b want 0", dmem.req); else passed++;
        total++; if (wb_valid !== 1'b0 || wb_pc !== 32'h0) $display("FAIL rstmid_wb got %b/%h want 0/0", wb_valid, wb_pc); else passed++;
        valid = 1'b0;
        step();
        reset = 1'b0;
        dmem.ready = 1'b1;
        dmem.rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        total++; if (stall !== 1'b0 || dmem.req !== 1'b0) $display("FAIL idle_ready got %b/%b want 0/0", stall, dmem.req); else passed++;
        step();
        dmem.ready = 1'b0;
        total++; if (wb_valid !== 1'b0 || dmem.req !== 1'b0) $display("FAIL idle_ready_after got %b/%b want 0/0", wb_valid, dmem.req); else passed++;
        run_memop(32'h3008, 32'h44, 32'h0, 5'd11, 3'b010, C_LD, 1, 32'hCAFE_F00D);
    endtask

    task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
        logic [31:0] addrs [2] = '{32'h102, 32'h3};
        logic [2:0]  fs    [2] = '{3'b010, 3'b001};
        for (int i = 0; i < 2; i++) begin
            drive(32'h4000, addrs[i], 32'h0, 5'd1, fs[i], (i == 0) ? C_LD : C_ST, 1'b1);
            @(negedge clk);
            total++; if (stall !== 1'b0 || dmem.req !== 1'b0) $display("FAIL mis_nostall got %b/%b want 0/0", stall, dmem.req); else passed++;
            step();
            valid = 1'b0;
            total++; if (mis !== 1'b1) $display("FAIL mis_pulse got %b want 1", mis); else passed++;
            total++; if (badaddr !== addrs[i]) $display("FAIL mis_badaddr got %h want %h", badaddr, addrs[i]); else passed++;
            total++; if (wb_valid !== 1'b0 || dmem.req !== 1'b0) $display("FAIL mis_wb got %b/%b want 0/0", wb_valid, dmem.req); else passed++;
            step();
            total++; if (mis !== 1'b0) $display("FAIL mis_end got %b want 0", mis); else passed++;
        end
`else
        run_memop(32'h4000, 32'h102, 32'h0, 5'd1, 3'b010, C_LD, 0, 32'h1122_3344);
        total++; if (obs_be !== 4'hF || wb_data !== 32'h1122_3344) $display("FAIL mis_issue got %b/%h want 1111/11223344", obs_be, wb_data); else passed++;
        total++; if (mis !== 1'b0 || badaddr !== 32'h0) $display("FAIL mis_tied got %b/%h want 0/0", mis, badaddr); else passed++;
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int kind = $urandom_range(0, 3);
            logic [31:0] a = $urandom();
            logic [2:0]  f = 3'($urandom_range(0, 7));
            logic [CW-1:0] c = CW'($urandom());
`ifdef MEM_MISALIGN_TRAP_EN
            if (m_misal(f, a)) a = a & ~32'h3;
`else
            if (m_misal(f, a)) a = a;
`endif
            case (kind)
                0: run_alu($urandom(), a, 5'($urandom()), c & ~C_MASK, 1'($urandom()));
                1: run_alu($urandom(), a, 5'($urandom()), c, 1'b0);
                2: run_memop($urandom(), a, $urandom(), 5'($urandom()), f,
                             (c & ~C_MASK) | C_LD, $urandom_range(0, 3), $urandom());
                default: run_memop($urandom(), a, $urandom(), 5'($urandom()), f,
                                   (c & ~C_MASK) | C_ST | (c & C_LD), $urandom_range(0, 3), $urandom());
            endcase
        end
    endtask

    initial begin
        C_LD = '0; C_LD[RB] = 1'b1;
        C_ST = '0; C_ST[WB] = 1'b1;
        C_MASK = C_LD | C_ST;
        test_reset();
        test_spec_vectors();
        test_back_to_back();
        test_reset_mid_access();
        test_misalign();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
